// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an 8-bit FIFO and sends each one as an
// asynchronous UART frame (start, 8 data bits LSB first, optional even
// parity, 1 or 2 stop bits). All outputs are registered. They are loaded from
// the next-state values, so each output changes on the same edge as the state
// change that it belongs to.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        FIFO_EMPTY_N,
  input  logic [7:0]  FIFO_DATA,
  output logic        FIFO_READ,
  output logic        TX,
  output logic        BUSY,
  output logic        BYTE_DONE,
  output logic [15:0] FRAME_COUNT
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic PAR_ON    = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  // Even parity bit: the XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic [2:0]        state_r,     state_nxt_s;
  logic [BAUD_W-1:0] baud_cnt_r,  baud_nxt_s;
  logic [2:0]        bit_cnt_r,   bit_nxt_s;
  logic              stop_cnt_r,  stop_nxt_s;
  logic [7:0]        shift_r,     shift_nxt_s;
  logic              parity_r,    parity_nxt_s;
  logic [15:0]       frame_count_r, count_nxt_s;
  logic              tx_r, tx_nxt_s;
  logic              fifo_read_r, read_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              byte_done_r, done_nxt_s;
  logic              baud_last_s;

  assign baud_last_s = (baud_cnt_r == BAUD_LAST);

  // Next-state logic: frame sequencing, baud/bit/stop counting, data capture.
  always_comb begin
    state_nxt_s  = state_r;
    baud_nxt_s   = baud_cnt_r;
    bit_nxt_s    = bit_cnt_r;
    stop_nxt_s   = stop_cnt_r;
    shift_nxt_s  = shift_r;
    parity_nxt_s = parity_r;
    count_nxt_s  = frame_count_r;
    case (state_r)
      ST_IDLE: begin
        if (ENABLE && FIFO_EMPTY_N) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_LOAD;
      end
      ST_LOAD: begin
        shift_nxt_s  = FIFO_DATA;
        parity_nxt_s = even_parity(FIFO_DATA);
        baud_nxt_s   = BAUD_ZERO;
        bit_nxt_s    = 3'd0;
        stop_nxt_s   = 1'b0;
        state_nxt_s  = ST_START;
      end
      ST_START: begin
        if (baud_last_s) begin
          baud_nxt_s  = BAUD_ZERO;
          bit_nxt_s   = 3'd0;
          state_nxt_s = ST_DATA;
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_nxt_s = BAUD_ZERO;
          if (bit_cnt_r == 3'd7) begin
            bit_nxt_s  = 3'd0;
            stop_nxt_s = 1'b0;
            if (PAR_ON) begin
              state_nxt_s = ST_PARITY;
            end else begin
              state_nxt_s = ST_STOP;
            end
          end else begin
            bit_nxt_s   = bit_cnt_r + 3'd1;
            shift_nxt_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      ST_PARITY: begin
        if (baud_last_s) begin
          baud_nxt_s  = BAUD_ZERO;
          stop_nxt_s  = 1'b0;
          state_nxt_s = ST_STOP;
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_last_s) begin
          baud_nxt_s = BAUD_ZERO;
          if (stop_cnt_r == STOP_LAST) begin
            stop_nxt_s  = 1'b0;
            count_nxt_s = frame_count_r + 16'd1;
            state_nxt_s = ST_IDLE;
          end else begin
            stop_nxt_s = 1'b1;
          end
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      default: begin
        baud_nxt_s  = BAUD_ZERO;
        bit_nxt_s   = 3'd0;
        stop_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, so the output registers line up with it.
  always_comb begin
    case (state_nxt_s)
      ST_START:  tx_nxt_s = 1'b0;
      ST_DATA:   tx_nxt_s = shift_nxt_s[0];
      ST_PARITY: tx_nxt_s = parity_nxt_s;
      default:   tx_nxt_s = 1'b1;
    endcase
    read_nxt_s = (state_nxt_s == ST_FETCH);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_STOP) && (stop_nxt_s == STOP_LAST) &&
                 (baud_nxt_s == BAUD_LAST);
  end

  // State, datapath and output registers; reset returns the line to idle high.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r       <= ST_IDLE;
      baud_cnt_r    <= BAUD_ZERO;
      bit_cnt_r     <= 3'd0;
      stop_cnt_r    <= 1'b0;
      shift_r       <= 8'd0;
      parity_r      <= 1'b0;
      frame_count_r <= 16'd0;
      tx_r          <= 1'b1;
      fifo_read_r   <= 1'b0;
      busy_r        <= 1'b0;
      byte_done_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      baud_cnt_r    <= baud_nxt_s;
      bit_cnt_r     <= bit_nxt_s;
      stop_cnt_r    <= stop_nxt_s;
      shift_r       <= shift_nxt_s;
      parity_r      <= parity_nxt_s;
      frame_count_r <= count_nxt_s;
      tx_r          <= tx_nxt_s;
      fifo_read_r   <= read_nxt_s;
      busy_r        <= busy_nxt_s;
      byte_done_r   <= done_nxt_s;
    end
  end

  assign TX          = tx_r;
  assign FIFO_READ   = fifo_read_r;
  assign BUSY        = busy_r;
  assign BYTE_DONE   = byte_done_r;
  assign FRAME_COUNT = frame_count_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx. The first instance (8N1, 4 clocks/bit) is fed from
// a queue-based FIFO model. The second instance (8E2, 4 clocks/bit) is driven
// directly. Line waveforms are compared cycle by cycle with expected bit
// patterns, which come either from hand-written tables or from a reference
// model of the frame format.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic fifo_empty_n = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic fifo_read, tx, busy, byte_done;
  logic [15:0] frame_count;

  logic enable_p = 1'b0;
  logic empty_n_p = 1'b0;
  logic [7:0] data_p = 8'h00;
  logic read_p, tx_p, busy_p, done_p;
  logic [15:0] count_p;

  logic push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fifo_q[$];
  int read_cnt = 0, bad_read = 0, bad_pop = 0, read_cnt_p = 0;
  int vectors = 0, miscompares = 0;
  logic [15:0] exp_count = 16'd0, exp_count_p = 16'd0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line bits, first bit sent in the MSB
  } vec_t;
  vec_t table_v[6];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(enable), .FIFO_EMPTY_N(fifo_empty_n),
    .FIFO_DATA(fifo_data), .FIFO_READ(fifo_read), .TX(tx), .BUSY(busy),
    .BYTE_DONE(byte_done), .FRAME_COUNT(frame_count));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(enable_p), .FIFO_EMPTY_N(empty_n_p),
    .FIFO_DATA(data_p), .FIFO_READ(read_p), .TX(tx_p), .BUSY(busy_p),
    .BYTE_DONE(done_p), .FRAME_COUNT(count_p));

  always #5 clk = ~clk;

  // FIFO model: registered read data and empty flag.
  always @(posedge clk) begin
    if (push_en) fifo_q.push_back(push_data);
    if (fifo_read) begin
      if (fifo_q.size() == 0) bad_pop <= bad_pop + 1;
      else fifo_data <= fifo_q.pop_front();
    end
    fifo_empty_n <= (fifo_q.size() != 0);
  end

  // Pop-strobe monitor.
  always @(posedge clk) begin
    if (fifo_read) read_cnt <= read_cnt + 1;
    if (fifo_read && !fifo_empty_n) bad_read <= bad_read + 1;
    if (read_p) read_cnt_p <= read_cnt_p + 1;
  end

  // Reference frame, 8N1: start, D0..D7, stop.
  function automatic logic [9:0] line_model(input logic [7:0] b);
    logic [9:0] p;
    p[9] = 1'b0;
    for (int j = 0; j < 8; j++) p[8-j] = b[j];
    p[0] = 1'b1;
    return p;
  endfunction

  // Reference frame, 8E2: start, D0..D7, even parity, two stops.
  function automatic logic [11:0] line_model_p(input logic [7:0] b);
    logic [11:0] p;
    int ones;
    ones = 0;
    p[11] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      p[10-j] = b[j];
      ones = ones + int'(b[j]);
    end
    p[2] = ((ones % 2) == 1) ? 1'b1 : 1'b0;
    p[1] = 1'b1;
    p[0] = 1'b1;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_data = b;
    push_en = 1'b1;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic wait_read(input string name, input int max_wait, output int waited, output bit ok);
    waited = 0;
    ok = 1'b0;
    while (waited < max_wait && !ok) begin
      @(negedge clk);
      waited++;
      if (fifo_read === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no FIFO_READ within %0d cycles", name, max_wait);
    end
  endtask

  // Waits for the pop, then checks every cycle from load to the idle after the frame.
  task automatic expect_frame(input string name, input logic [9:0] pat, input int max_wait,
                              input int drop_at, output int waited);
    bit ok;
    wait_read(name, max_wait, waited, ok);
    if (ok) begin
      chk({name, "_fetch"}, {30'd0, busy, tx}, {30'd0, 1'b1, 1'b1});
      @(negedge clk);
      chk({name, "_load"}, {30'd0, fifo_read, tx}, {30'd0, 1'b0, 1'b1});
      for (int i = 0; i < 10*CPB; i++) begin
        @(negedge clk);
        chk({name, "_line"}, {30'd0, tx, byte_done}, {30'd0, pat[9 - i/CPB], 1'(i == 10*CPB-1)});
        if (i == drop_at) enable = 1'b0;
      end
      @(negedge clk);
      exp_count = exp_count + 16'd1;
      chk({name, "_busy_end"}, 32'(busy), 32'd0);
      chk({name, "_count"}, 32'(frame_count), 32'(exp_count));
    end
  endtask

  task automatic send_p(input string name, input logic [7:0] b, input logic [11:0] pat);
    int waited;
    int r0;
    bit ok;
    r0 = read_cnt_p;
    data_p = b;
    empty_n_p = 1'b1;
    enable_p = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (waited < 10 && !ok) begin
      @(negedge clk);
      waited++;
      if (read_p === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no FIFO_READ within 10 cycles", name);
    end else begin
      @(posedge clk);
      #1;
      empty_n_p = 1'b0;
      enable_p = 1'b0;
      @(negedge clk);
      chk({name, "_load"}, 32'(tx_p), 32'd1);
      for (int i = 0; i < 12*CPB; i++) begin
        @(negedge clk);
        chk({name, "_line"}, {30'd0, tx_p, done_p}, {30'd0, pat[11 - i/CPB], 1'(i == 12*CPB-1)});
      end
      @(negedge clk);
      exp_count_p = exp_count_p + 16'd1;
      chk({name, "_busy_end"}, 32'(busy_p), 32'd0);
      chk({name, "_count"}, 32'(count_p), 32'(exp_count_p));
      chk({name, "_pops"}, 32'(read_cnt_p - r0), 32'd1);
    end
  endtask

  initial begin
    int waited;
    int r0;
    int n;
    bit ok;
    logic [7:0] rb[4];

    table_v[0] = '{8'hA5, 10'b0101001011};
    table_v[1] = '{8'h00, 10'b0000000001};
    table_v[2] = '{8'hFF, 10'b0111111111};
    table_v[3] = '{8'h01, 10'b0100000001};
    table_v[4] = '{8'h80, 10'b0000000011};
    table_v[5] = '{8'h3C, 10'b0001111001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read", 32'(fifo_read), 32'd0);
    chk("rst_done", 32'(byte_done), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Reset during data bit 3; the popped byte is lost.
    push(8'h3C);
    push(8'h5A);
    enable = 1'b1;
    wait_read("rst_mid_fetch", 10, waited, ok);
    repeat (19) @(negedge clk);
    chk("rst_mid_bit3", {30'd0, busy, tx}, {30'd0, 1'b1, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_now", {28'd0, tx, busy, fifo_read, byte_done}, {28'd0, 4'b1000});
    chk("rst_mid_count", 32'(frame_count), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_mid_hold", {29'd0, tx, busy, fifo_read}, {29'd0, 3'b100});
    end
    rst_n = 1'b1;
    expect_frame("after_rst", 10'b0010110101, 5, -1, waited);
    chk("after_rst_latency", 32'(waited), 32'd1);

    // Table of single-byte frames
    for (int k = 0; k < 6; k++) begin
      enable = 1'b0;
      push(table_v[k].data);
      enable = 1'b1;
      expect_frame($sformatf("tbl%0d", k), table_v[k].line, 5, -1, waited);
      chk($sformatf("tbl%0d_latency", k), 32'(waited), 32'd1);
    end

    // Back-to-back frames, then the empty guard
    enable = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    r0 = read_cnt;
    enable = 1'b1;
    expect_frame("b2b0", 10'b0100000001, 5, -1, waited);
    expect_frame("b2b1", 10'b0010000001, 5, -1, waited);
    chk("b2b1_gap", 32'(waited), 32'd1);
    expect_frame("b2b2", 10'b0110000001, 5, -1, waited);
    chk("b2b2_gap", 32'(waited), 32'd1);
    repeat (20) @(negedge clk);
    chk("b2b_pops", 32'(read_cnt - r0), 32'd3);
    chk("b2b_idle_tx", 32'(tx), 32'd1);
    chk("empty_guard", 32'(bad_read + bad_pop), 32'd0);

    // ENABLE dropped during the first frame's data bits
    enable = 1'b0;
    push(8'hAA);
    push(8'h55);
    r0 = read_cnt;
    enable = 1'b1;
    expect_frame("drop1", 10'b0010101011, 5, 10, waited);
    repeat (30) @(negedge clk);
    chk("drop_pops", 32'(read_cnt - r0), 32'd1);
    chk("drop_idle", {30'd0, tx, busy}, {30'd0, 1'b1, 1'b0});
    enable = 1'b1;
    expect_frame("drop2", 10'b0101010101, 5, -1, waited);
    chk("drop2_latency", 32'(waited), 32'd1);

    // Frame counter wrap
    force dut.frame_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_r;
    @(negedge clk);
    chk("wrap_preset", 32'(frame_count), 32'h0000FFFF);
    exp_count = 16'hFFFF;
    enable = 1'b0;
    push(8'h81);
    enable = 1'b1;
    expect_frame("wrap", 10'b0100000011, 5, -1, waited);

    // Random batches against the frame model
    for (int batch = 0; batch < 4; batch++) begin
      n = int'($urandom_range(1, 4));
      enable = 1'b0;
      for (int k = 0; k < n; k++) begin
        rb[k] = 8'($urandom_range(0, 255));
        push(rb[k]);
      end
      enable = 1'b1;
      for (int k = 0; k < n; k++) begin
        expect_frame($sformatf("rnd%0d_%0d", batch, k), line_model(rb[k]), 5, -1, waited);
        chk($sformatf("rnd%0d_%0d_lat", batch, k), 32'(waited), 32'd1);
      end
      repeat ($urandom_range(0, 7)) @(negedge clk);
    end
    chk("final_guard", 32'(bad_read + bad_pop), 32'd0);

    // Parity and two stop bits
    send_p("par07", 8'h07, 12'b011100000111);
    for (int k = 0; k < 3; k++) begin
      rb[0] = 8'($urandom_range(0, 255));
      send_p($sformatf("par_rnd%0d", k), rb[0], line_model_p(rb[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
